ca_ingr_snd_responder: RTL
==========================

// Module: ca_ingr_snd_responder
// PURPOSE
// Receiving end of the ingress send req/resp/data protocol. Accepts a request, grants a
// response whose burst_length is clamped to free buffer credit, then sinks that many data bytes.
// Received beats go to the downstream buffer.
// Sits opposite the ingress sender; its traffic must pass the ingress send protocol monitor clean.
// PARAMETERS
// MAX_BURST_LENGTH  16'd4096  largest legal req burst_length, in bytes
// BUFFER_BYTES      32'd65536 total downstream buffer credit, in bytes; also the credit reset value
// PORTS
// ap_clk            in   1   clock
// ap_rst            in   1   asynchronous reset, active-high
// req_tvalid/tready in/out 1 request handshake
// req_tdata         in   64  [15:0] channel, [32] sof, [33] eof, [63:48] burst_length in bytes, others reserved
// resp_tvalid/tready out/in 1 response handshake
// resp_tdata        out  64  same layout as req; burst_length holds the granted length
// data_tvalid/tready in/out 1 data handshake
// data_tdata        in   32  payload, 4 bytes per beat
// out_tvalid        out  1   registered copy of each accepted data beat; no backpressure
// out_tdata         out  32  payload
// out_tlast         out  1   last beat of the grant
// out_channel       out  16  channel of the current grant
// credit_ret_valid  in   1   pulse: downstream freed credit_ret_bytes
// credit_ret_bytes  in   16  bytes freed
// credit_avail      out  32  current free credit in bytes
// error_status      out  4   sticky: [0] req len 0, [1] req len > MAX, [2] credit overflow, [3] data while not in DATA
// error_clear       in   1   clears error_status; a same-cycle new error wins
// BEHAVIOUR
// - Reset values: ready/valid outputs 0, out_* 0, resp_tdata 0, error_status 0, credit_avail=BUFFER_BYTES, FSM=IDLE.
// - FSM IDLE: req_tready=1. On req handshake: latch req_tdata, compute grant, go RESP.
// - Grant rule: if len==0 or len>MAX_BURST_LENGTH, grant=0 and set error[0] or error[1].
//   Otherwise grant=min(len, credit_avail) in 17-bit arithmetic.
// - FSM RESP: resp_tvalid=1 from the cycle after req acceptance (1-cycle latency).
//   resp_tdata = latched req with [63:48]=grant; sof, eof and channel are echoed unchanged.
//   resp_tdata must stay stable until resp_tready.
// - On resp handshake: credit_avail -= grant. If grant==0, go IDLE; else load beats=ceil(grant/4) and go DATA.
// - FSM DATA: data_tready=1. Each handshake decrements beats.
//   Each accepted beat appears on out_* one cycle later.
//   out_tlast=1 on the beat where beats==1; that beat returns the FSM to IDLE.
//   A partial last word (grant%4!=0) is passed whole. Trailing bytes are ignored; credit is charged for grant only.
// - data_tready=0 outside DATA. data_tvalid while not in DATA sets error[3]; the beat is not consumed.
// - Credit: a return adds credit_ret_bytes in any state.
//   A return in the same cycle as the resp-handshake debit applies the net change.
//   If the result exceeds BUFFER_BYTES: saturate to BUFFER_BYTES and set error[2].
//   Credit never goes negative, since grant<=credit at grant time and returns only add.
// - Exactly one request is outstanding. req_tready is 0 in RESP and DATA, so a back-to-back req waits.
// - Reset mid-operation: FSM aborts to IDLE, credit restores to BUFFER_BYTES, out_tvalid drops immediately.
//   The partially transferred burst is lost; the sender is reset together with this block.
// TESTING
// - Reset: assert ap_rst mid-DATA -> all outputs at reset values, credit_avail=65536, req_tready=1 one cycle after release.
// - Full grant: req len=64, ch=5, sof=1, eof=1 -> resp len=64 with ch, sof, eof echoed
//   -> 16 beats accepted, out_tlast on 16th, credit_avail=65472.
// - Partial and zero credit: credit=40, req len=64 -> resp len=40, 10 beats, credit=0;
//   next req len=64 -> resp len=0, no DATA, FSM returns to IDLE.
// - Odd length: req len=6 -> resp len=6, 2 beats, out_tlast on 2nd, credit down by 6.
// - Simultaneous: credit=100, resp handshake grant=64 in the same cycle as return 32 -> credit=68.
//   Return 70000 total on full credit -> saturates at 65536, error[2]=1.
// - Illegal req: len=0 -> resp len=0, error[0]=1. Len=4097 -> resp len=0, error[1]=1.
//   error_clear -> 0. data_tvalid while IDLE -> error[3]=1, data_tready stays 0.

Source files
------------

// File: rtl/ca_ingr_snd_responder.sv
// Receiving end of the ingress send req/resp/data protocol: grants bursts clamped to
// free downstream credit, sinks the granted beats and forwards them as a registered stream.
module ca_ingr_snd_responder #(
  parameter logic [15:0] MAX_BURST_LENGTH = 16'd4096,
  parameter logic [31:0] BUFFER_BYTES     = 32'd65536
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        req_tvalid,
  output logic        req_tready,
  input  logic [63:0] req_tdata,
  output logic        resp_tvalid,
  input  logic        resp_tready,
  output logic [63:0] resp_tdata,
  input  logic        data_tvalid,
  output logic        data_tready,
  input  logic [31:0] data_tdata,
  output logic        out_tvalid,
  output logic [31:0] out_tdata,
  output logic        out_tlast,
  output logic [15:0] out_channel,
  input  logic        credit_ret_valid,
  input  logic [15:0] credit_ret_bytes,
  output logic [31:0] credit_avail,
  output logic [3:0]  error_status,
  input  logic        error_clear
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        req_hs_s;
  logic        resp_hs_s;
  logic        data_hs_s;
  logic [15:0] req_len_s;
  logic        len_zero_s;
  logic        len_big_s;
  logic [15:0] grant_s;
  logic [15:0] grant_r;
  logic [15:0] beats_r;
  logic [32:0] credit_sum_s;
  logic        credit_sat_s;
  logic [3:0]  err_new_s;

  assign req_hs_s   = req_tvalid & req_tready;
  assign resp_hs_s  = resp_tvalid & resp_tready;
  assign data_hs_s  = data_tvalid & data_tready;
  assign req_len_s  = req_tdata[63:48];
  assign len_zero_s = (req_len_s == 16'd0);
  assign len_big_s  = (req_len_s > MAX_BURST_LENGTH);

  // Grant: illegal lengths get nothing, otherwise the smaller of request and free credit.
  always_comb begin
    grant_s = 16'd0;
    if (len_zero_s || len_big_s) begin
      grant_s = 16'd0;
    end else if ({16'd0, req_len_s} <= credit_avail) begin
      grant_s = req_len_s;
    end else begin
      grant_s = credit_avail[15:0];
    end
  end

  // Net credit change for this cycle; the debit never exceeds the credit it was granted from.
  always_comb begin
    credit_sum_s = {1'b0, credit_avail}
                 + {17'd0, (credit_ret_valid ? credit_ret_bytes : 16'd0)}
                 - {17'd0, (resp_hs_s ? grant_r : 16'd0)};
    credit_sat_s = (credit_sum_s > {1'b0, BUFFER_BYTES});
    err_new_s    = {(data_tvalid && (state_r != ST_DATA)),
                    credit_sat_s,
                    (req_hs_s && len_big_s),
                    (req_hs_s && len_zero_s)};
  end

  // FSM state register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_hs_s) state_s = ST_RESP;
        else          state_s = ST_IDLE;
      end
      ST_RESP: begin
        if (resp_hs_s) state_s = (grant_r == 16'd0) ? ST_IDLE : ST_DATA;
        else           state_s = ST_RESP;
      end
      ST_DATA: begin
        if (data_hs_s && (beats_r == 16'd1)) state_s = ST_IDLE;
        else                                 state_s = ST_DATA;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they track the FSM with no comb path.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      req_tready   <= 1'b0;
      resp_tvalid  <= 1'b0;
      data_tready  <= 1'b0;
      resp_tdata   <= 64'd0;
      grant_r      <= 16'd0;
      beats_r      <= 16'd0;
      out_tvalid   <= 1'b0;
      out_tdata    <= 32'd0;
      out_tlast    <= 1'b0;
      out_channel  <= 16'd0;
      credit_avail <= BUFFER_BYTES;
      error_status <= 4'd0;
    end else begin
      req_tready  <= (state_s == ST_IDLE);
      resp_tvalid <= (state_s == ST_RESP);
      data_tready <= (state_s == ST_DATA);
      if (req_hs_s) begin
        resp_tdata  <= {grant_s, req_tdata[47:0]};
        grant_r     <= grant_s;
        out_channel <= req_tdata[15:0];
      end
      if (resp_hs_s) begin
        beats_r <= (grant_r + 16'd3) >> 2;
      end else if (data_hs_s) begin
        beats_r <= beats_r - 16'd1;
      end
      out_tvalid <= data_hs_s;
      out_tlast  <= data_hs_s && (beats_r == 16'd1);
      if (data_hs_s) out_tdata <= data_tdata;
      credit_avail <= credit_sat_s ? BUFFER_BYTES : credit_sum_s[31:0];
      error_status <= (error_clear ? 4'd0 : error_status) | err_new_s;
    end
  end

endmodule
